xillybus_stream_bridge: RTL and testbench
=========================================

XILLYBUS_STREAM_BRIDGE -- requirements
Module: xillybus_stream_bridge

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, width of the user stream data words (legal values 8, 16, 32, 64).
REQ-002 SHALL provide parameter DEPTH_LOG2, default 9, buffer depth of 2^DEPTH_LOG2 words (legal range 2..12).
REQ-003 SHALL have port bus_clk, input, 1, the sole clock; all logic is rising-edge.
REQ-004 SHALL have port trn_reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port user_w_wren, input, 1, host-to-FPGA write strobe.
REQ-006 SHALL have port user_w_data, input, DATA_W, host-to-FPGA write data.
REQ-007 SHALL have port user_w_full, output, 1, buffer full.
REQ-008 SHALL have port user_w_open, input, 1, write file open on the host.
REQ-009 SHALL have port user_r_rden, input, 1, FPGA-to-host read strobe.
REQ-010 SHALL have port user_r_data, output, DATA_W, read data.
REQ-011 SHALL have port user_r_empty, output, 1, buffer empty.
REQ-012 SHALL have port user_r_eof, output, 1, end-of-file toward the host.
REQ-013 SHALL have port user_r_open, input, 1, read file open on the host.
REQ-014 SHALL have port level, output, DEPTH_LOG2+1, current word count.
REQ-015 SHALL have port word_count, output, 32, count of delivered words.
REQ-016 SHALL have port GPIO_LED, output, 4, status LEDs.

Function
REQ-017 SHALL accept a write iff user_w_wren=1 and user_w_full=0 in that cycle; a write while full is dropped and sets the sticky flag ovf.
REQ-018 SHALL accept a read iff user_r_rden=1 and user_r_empty=0; user_r_data SHALL be valid on the cycle after the accepted read (standard FIFO, not FWFT); a read while empty is ignored and data is held.
REQ-019 SHALL perform a simultaneous accepted read and write in one cycle, leaving level unchanged; at full only the read is accepted.
REQ-020 SHALL register user_w_full (level==2^DEPTH_LOG2) and user_r_empty (level==0) from the post-update level, with no combinational path from strobes to flags.
REQ-021 SHALL wrap the read and write pointers modulo 2^DEPTH_LOG2.
REQ-022 SHALL implement the states IDLE, STREAM, DRAIN and EOF.
REQ-023 Transitions SHALL be: IDLE->STREAM when user_w_open=1; STREAM->DRAIN on a 1->0 edge of user_w_open; DRAIN->EOF when level==0; EOF->IDLE when user_r_open=0.
REQ-024 In any state, user_w_open=0 with user_r_open=0 SHALL force IDLE next cycle, flush both pointers (level=0) and clear ovf.
REQ-025 DRAIN->STREAM SHALL occur if user_w_open rises again before the buffer empties (no EOF issued).
REQ-026 SHALL accept writes only in STREAM; writes in other states are dropped without setting ovf.
REQ-027 SHALL assert user_r_eof only in EOF, where user_r_empty=1 is guaranteed.
REQ-028 GPIO_LED SHALL be: [0]=!user_r_empty, [1]=user_w_full, [2]=ovf, [3]=(state==EOF).

Reset
REQ-029 On trn_reset_n=0 at a clock edge: state=IDLE, pointers=0, level=0, user_w_full=0, user_r_empty=1, user_r_eof=0, user_r_data=0, ovf=0, word_count=0, GPIO_LED=0.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered data; no partial word SHALL be delivered afterwards.

Configuration
REQ-031 Macro XB_BRIDGE_WORD_COUNT_EN defined: word_count SHALL increment on each accepted read, wrap from 0xFFFFFFFF to 0, and clear on entry to IDLE.
REQ-032 Macro XB_BRIDGE_WORD_COUNT_EN undefined: word_count SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-033 Open write, write 0x11,0x22,0x33, then rden x3 -> data 0x11,0x22,0x33 each one cycle after its rden; empty=1 after the third.
REQ-034 DEPTH_LOG2=2: write 5 words -> full=1 after the 4th, 5th dropped, LED[2]=1, level=4.
REQ-035 At level=4 (full), wren+rden in the same cycle -> read accepted, write dropped, level=3, full=0.
REQ-036 Two words buffered, drop user_w_open -> DRAIN; read both -> EOF next cycle, user_r_eof=1, empty=1; drop user_r_open -> IDLE, eof=0.
REQ-037 Reset pulse with level=3 -> next cycle level=0, empty=1, word_count=0, eof=0.
REQ-038 With XB_BRIDGE_WORD_COUNT_EN defined and word_count preloaded to 0xFFFFFFFF (forced), one accepted read -> word_count=0.

Source files
------------

// File: rtl/xillybus_stream_bridge_if.sv
// Host-side stream bus of the Xillybus bridge: write/read handshakes plus status.
interface xillybus_stream_bridge_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 9
);
  logic                  user_w_wren;
  logic [DATA_W-1:0]     user_w_data;
  logic                  user_w_full;
  logic                  user_w_open;
  logic                  user_r_rden;
  logic [DATA_W-1:0]     user_r_data;
  logic                  user_r_empty;
  logic                  user_r_eof;
  logic                  user_r_open;
  logic [DEPTH_LOG2:0]   level;
  logic [31:0]           word_count;
  logic [3:0]            GPIO_LED;

  modport master (
    output user_w_wren, user_w_data, user_w_open, user_r_rden, user_r_open,
    input  user_w_full, user_r_data, user_r_empty, user_r_eof, level, word_count, GPIO_LED
  );

  modport slave (
    input  user_w_wren, user_w_data, user_w_open, user_r_rden, user_r_open,
    output user_w_full, user_r_data, user_r_empty, user_r_eof, level, word_count, GPIO_LED
  );
endinterface

// File: rtl/xillybus_stream_bridge.sv
// Host-to-FPGA stream buffer with open/drain/EOF session tracking toward the host reader.
// Optional delivered-word counter enabled by defining XB_BRIDGE_WORD_COUNT_EN.
module xillybus_stream_bridge #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                     bus_clk,
  input  logic                     trn_reset_n,
  xillybus_stream_bridge_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, EOF} state_t;

  state_t                 state_q, state_d;
  logic                   w_open_q;
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   full_q, empty_q, eof_q, ovf_q, ovf_d;
  logic [3:0]             led_q;
  logic [DATA_W-1:0]      r_data_q;
  logic [DATA_W-1:0]      mem [DEPTH];
  logic                   wr_req, wr_acc, rd_acc, flush;

  // Session FSM, handshake acceptance and next level
  always_comb begin
    state_d = state_q;
    wr_req  = bus.user_w_wren && (state_q == STREAM);
    wr_acc  = wr_req && !full_q;
    rd_acc  = bus.user_r_rden && !empty_q;
    flush   = 1'b0;
    ovf_d   = ovf_q || (wr_req && full_q);
    level_d = level_q;

    case (state_q)
      IDLE:    if (bus.user_w_open) state_d = STREAM;
      STREAM:  if (w_open_q && !bus.user_w_open) state_d = DRAIN;
      DRAIN: begin
        // A reopen before the buffer empties resumes streaming without EOF
        if (bus.user_w_open)        state_d = STREAM;
        else if (level_q == '0)     state_d = EOF;
      end
      EOF:     if (!bus.user_r_open) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Both files closed: abandon the session and everything buffered
    if (!bus.user_w_open && !bus.user_r_open) begin
      state_d = IDLE;
      flush   = 1'b1;
      wr_acc  = 1'b0;
      rd_acc  = 1'b0;
      ovf_d   = 1'b0;
    end

    if (flush) level_d = '0;
    else       level_d = level_q + LVL_W'(wr_acc) - LVL_W'(rd_acc);
  end

  always_ff @(posedge bus_clk) begin
    if (!trn_reset_n) begin
      state_q  <= IDLE;
      w_open_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      eof_q    <= 1'b0;
      ovf_q    <= 1'b0;
      led_q    <= '0;
      r_data_q <= '0;
    end else begin
      state_q  <= state_d;
      w_open_q <= bus.user_w_open;
      level_q  <= level_d;
      full_q   <= (level_d == LVL_W'(DEPTH));
      empty_q  <= (level_d == '0);
      eof_q    <= (state_d == EOF);
      ovf_q    <= ovf_d;
      led_q    <= {(state_d == EOF), ovf_d, (level_d == LVL_W'(DEPTH)), (level_d != '0)};
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_acc) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
        if (rd_acc) begin
          rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
          r_data_q <= mem[rd_ptr_q];
        end
      end
    end
  end

  // Buffer storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge bus_clk) begin
    if (trn_reset_n && wr_acc) mem[wr_ptr_q] <= bus.user_w_data;
  end

`ifdef XB_BRIDGE_WORD_COUNT_EN
  logic [31:0] wc_q;

  always_ff @(posedge bus_clk) begin
    if (!trn_reset_n || state_d == IDLE) wc_q <= '0;
    else if (rd_acc)                     wc_q <= wc_q + 32'd1;
  end

  assign bus.word_count = wc_q;
`else
  assign bus.word_count = '0;
`endif

  assign bus.user_w_full  = full_q;
  assign bus.user_r_empty = empty_q;
  assign bus.user_r_eof   = eof_q;
  assign bus.user_r_data  = r_data_q;
  assign bus.level        = level_q;
  assign bus.GPIO_LED     = led_q;
endmodule

// File: tb/tb_xillybus_stream_bridge.sv
// Scoreboard bench for xillybus_stream_bridge with a 4-word buffer.
module tb_xillybus_stream_bridge;
  localparam int unsigned DW    = 32;
  localparam int unsigned DL    = 2;
  localparam int unsigned DEPTH = 4;

  logic bus_clk = 1'b0;
  logic trn_reset_n = 1'b0;
  always #5 bus_clk = ~bus_clk;

  xillybus_stream_bridge_if #(.DATA_W(DW), .DEPTH_LOG2(DL)) bus ();

  xillybus_stream_bridge #(.DATA_W(DW), .DEPTH_LOG2(DL)) dut (
    .bus_clk     (bus_clk),
    .trn_reset_n (trn_reset_n),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];
  int mdl_level = 0;
  logic mdl_stream = 1'b0;
  logic [31:0] mdl_wc = '0;

  task automatic cyc();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic model_flush();
    exp_q.delete();
    mdl_level  = 0;
    mdl_stream = 1'b0;
    mdl_wc     = '0;
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    bus.user_w_wren = 1'b1;
    bus.user_w_data = d;
    cyc();
    bus.user_w_wren = 1'b0;
    if (mdl_stream && mdl_level < DEPTH) begin
      exp_q.push_back(d);
      mdl_level++;
    end
  endtask

  // Read strobe; the word popped from the scoreboard must appear after the edge
  task automatic do_read(input string tag);
    logic [DW-1:0] e;
    bus.user_r_rden = 1'b1;
    cyc();
    bus.user_r_rden = 1'b0;
    if (mdl_level > 0) begin
      e = exp_q.pop_front();
      mdl_level--;
`ifdef XB_BRIDGE_WORD_COUNT_EN
      mdl_wc = mdl_wc + 32'd1;
`endif
      checks++;
      if (bus.user_r_data !== e) begin
        errors++;
        $display("FAIL %s user_r_data got %h expected %h", tag, bus.user_r_data, e);
      end
    end
  endtask

  // Simultaneous write and read strobes in one cycle
  task automatic do_rw(input logic [DW-1:0] d, input string tag);
    logic [DW-1:0] e;
    logic rd_ok, wr_ok;
    rd_ok = (mdl_level > 0);
    wr_ok = mdl_stream && (mdl_level < DEPTH);
    bus.user_w_wren = 1'b1;
    bus.user_w_data = d;
    bus.user_r_rden = 1'b1;
    cyc();
    bus.user_w_wren = 1'b0;
    bus.user_r_rden = 1'b0;
    if (wr_ok) begin
      exp_q.push_back(d);
      mdl_level++;
    end
    if (rd_ok) begin
      e = exp_q.pop_front();
      mdl_level--;
`ifdef XB_BRIDGE_WORD_COUNT_EN
      mdl_wc = mdl_wc + 32'd1;
`endif
      checks++;
      if (bus.user_r_data !== e) begin
        errors++;
        $display("FAIL %s user_r_data got %h expected %h", tag, bus.user_r_data, e);
      end
    end
  endtask

  task automatic test_reset();
    trn_reset_n = 1'b0;
    cyc();
    cyc();
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d expected 0", bus.level); end
    checks++; if (bus.user_r_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b expected 1", bus.user_r_empty); end
    checks++; if (bus.user_w_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b expected 0", bus.user_w_full); end
    checks++; if (bus.user_r_eof !== 1'b0) begin errors++; $display("FAIL reset_eof got %b expected 0", bus.user_r_eof); end
    checks++; if (bus.user_r_data !== '0) begin errors++; $display("FAIL reset_data got %h expected 0", bus.user_r_data); end
    checks++; if (bus.word_count !== 32'd0) begin errors++; $display("FAIL reset_wc got %h expected 0", bus.word_count); end
    checks++; if (bus.GPIO_LED !== 4'd0) begin errors++; $display("FAIL reset_led got %b expected 0000", bus.GPIO_LED); end
    trn_reset_n = 1'b1;
    cyc();
    model_flush();
  endtask

  task automatic test_basic();
    bus.user_w_open = 1'b1;
    bus.user_r_open = 1'b1;
    cyc();
    mdl_stream = 1'b1;
    do_write(32'h11);
    do_write(32'h22);
    do_write(32'h33);
    checks++; if (bus.level !== 3'(mdl_level)) begin errors++; $display("FAIL basic_level got %0d expected %0d", bus.level, mdl_level); end
    checks++; if (bus.user_r_empty !== 1'b0) begin errors++; $display("FAIL basic_not_empty got %b expected 0", bus.user_r_empty); end
    do_read("basic_rd0");
    do_read("basic_rd1");
    do_read("basic_rd2");
    checks++; if (bus.user_r_empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b expected 1", bus.user_r_empty); end
    do_read("basic_rd_empty");
    checks++; if (bus.user_r_data !== 32'h33) begin errors++; $display("FAIL basic_hold got %h expected 00000033", bus.user_r_data); end
    do_write(32'h44);
    do_rw(32'h55, "basic_rw");
    checks++; if (bus.level !== 3'(mdl_level)) begin errors++; $display("FAIL basic_rw_level got %0d expected %0d", bus.level, mdl_level); end
    do_read("basic_rd3");
    checks++; if (bus.word_count !== mdl_wc) begin errors++; $display("FAIL basic_wc got %h expected %h", bus.word_count, mdl_wc); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) do_write(32'hA1 + 32'(i));
    checks++; if (bus.user_w_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b expected 1", bus.user_w_full); end
    checks++; if (bus.GPIO_LED[2] !== 1'b0) begin errors++; $display("FAIL full_no_ovf got %b expected 0", bus.GPIO_LED[2]); end
    do_write(32'hA5);
    checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL full_level got %0d expected 4", bus.level); end
    checks++; if (bus.GPIO_LED !== 4'b0111) begin errors++; $display("FAIL full_led got %b expected 0111", bus.GPIO_LED); end
    do_rw(32'hB0, "full_rw");
    checks++; if (bus.level !== 3'd3) begin errors++; $display("FAIL full_rw_level got %0d expected 3", bus.level); end
    checks++; if (bus.user_w_full !== 1'b0) begin errors++; $display("FAIL full_rw_full got %b expected 0", bus.user_w_full); end
    do_read("full_rd1");
    do_read("full_rd2");
    do_read("full_rd3");
    checks++; if (bus.GPIO_LED[2] !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b expected 1", bus.GPIO_LED[2]); end
    bus.user_w_open = 1'b0;
    bus.user_r_open = 1'b0;
    cyc();
    model_flush();
    checks++; if (bus.GPIO_LED !== 4'd0) begin errors++; $display("FAIL flush_led got %b expected 0000", bus.GPIO_LED); end
  endtask

  task automatic test_drain_eof();
    bus.user_w_open = 1'b1;
    bus.user_r_open = 1'b1;
    cyc();
    mdl_stream = 1'b1;
    do_write(32'hC1);
    do_write(32'hC2);
    bus.user_w_open = 1'b0;
    cyc();
    mdl_stream = 1'b0;
    do_write(32'hC3);
    checks++; if (bus.level !== 3'd2) begin errors++; $display("FAIL drain_level got %0d expected 2", bus.level); end
    checks++; if (bus.GPIO_LED[2] !== 1'b0) begin errors++; $display("FAIL drain_no_ovf got %b expected 0", bus.GPIO_LED[2]); end
    checks++; if (bus.user_r_eof !== 1'b0) begin errors++; $display("FAIL drain_eof_early got %b expected 0", bus.user_r_eof); end
    do_read("drain_rd0");
    do_read("drain_rd1");
    for (int i = 0; i < 5 && bus.user_r_eof !== 1'b1; i++) cyc();
    checks++; if (bus.user_r_eof !== 1'b1) begin errors++; $display("FAIL eof_set got %b expected 1", bus.user_r_eof); end
    checks++; if (bus.user_r_empty !== 1'b1) begin errors++; $display("FAIL eof_empty got %b expected 1", bus.user_r_empty); end
    checks++; if (bus.GPIO_LED !== 4'b1000) begin errors++; $display("FAIL eof_led got %b expected 1000", bus.GPIO_LED); end
    bus.user_r_open = 1'b0;
    cyc();
    model_flush();
    checks++; if (bus.user_r_eof !== 1'b0) begin errors++; $display("FAIL eof_clear got %b expected 0", bus.user_r_eof); end
    checks++; if (bus.word_count !== mdl_wc) begin errors++; $display("FAIL idle_wc got %h expected %h", bus.word_count, mdl_wc); end
  endtask

  task automatic test_reopen();
    bus.user_w_open = 1'b1;
    bus.user_r_open = 1'b1;
    cyc();
    mdl_stream = 1'b1;
    do_write(32'hD1);
    bus.user_w_open = 1'b0;
    cyc();
    mdl_stream = 1'b0;
    bus.user_w_open = 1'b1;
    cyc();
    mdl_stream = 1'b1;
    do_write(32'hD2);
    checks++; if (bus.level !== 3'd2) begin errors++; $display("FAIL reopen_level got %0d expected 2", bus.level); end
    checks++; if (bus.user_r_eof !== 1'b0) begin errors++; $display("FAIL reopen_eof got %b expected 0", bus.user_r_eof); end
    do_read("reopen_rd0");
    do_read("reopen_rd1");
  endtask

  task automatic test_reset_mid();
    do_write(32'hE1);
    do_write(32'hE2);
    do_write(32'hE3);
    trn_reset_n = 1'b0;
    cyc();
    model_flush();
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL rstmid_level got %0d expected 0", bus.level); end
    checks++; if (bus.user_r_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b expected 1", bus.user_r_empty); end
    checks++; if (bus.word_count !== 32'd0) begin errors++; $display("FAIL rstmid_wc got %h expected 0", bus.word_count); end
    checks++; if (bus.user_r_eof !== 1'b0) begin errors++; $display("FAIL rstmid_eof got %b expected 0", bus.user_r_eof); end
    trn_reset_n = 1'b1;
    do_read("rstmid_rd_empty");
    checks++; if (bus.user_r_data !== '0) begin errors++; $display("FAIL rstmid_stale got %h expected 0", bus.user_r_data); end
    mdl_stream = 1'b1;
    do_write(32'hF1);
    do_read("rstmid_rd_new");
  endtask

`ifdef XB_BRIDGE_WORD_COUNT_EN
  task automatic test_wc_wrap();
    do_write(32'h77);
    force dut.wc_q = 32'hFFFF_FFFF;
    cyc();
    release dut.wc_q;
    mdl_wc = 32'hFFFF_FFFF;
    do_read("wc_rd");
    checks++; if (bus.word_count !== mdl_wc) begin errors++; $display("FAIL wc_wrap got %h expected %h", bus.word_count, mdl_wc); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.user_w_wren = 1'b0;
    bus.user_w_data = '0;
    bus.user_w_open = 1'b0;
    bus.user_r_rden = 1'b0;
    bus.user_r_open = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_drain_eof();
    test_reopen();
    test_reset_mid();
`ifdef XB_BRIDGE_WORD_COUNT_EN
    test_wc_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
